// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared types and constants for the next-PC controller.
//   pc_sel_e : encoding of the PC register update select
//   state_e  : controller FSM states
//   F3_*     : branch condition codes carried in funct3
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,  // PC + 4
    PC_REL  = 2'b01,  // PC + pc_target
    PC_ABS  = 2'b10,  // PC = pc_target
    PC_ZERO = 2'b11   // PC = 0
  } pc_sel_e;

  typedef enum logic [1:0] {
    RESET = 2'b00,
    RUN   = 2'b01,
    HALT  = 2'b10
  } state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Control-transfer targets must be word aligned; bit 1 set means a trap.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1];
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_cmp.sv
// branch_cmp
// Purely combinational branch condition evaluation.
//   funct3  in  3   branch condition code
//   rs1_val in  32  first operand
//   rs2_val in  32  second operand
//   taken   out 1   condition holds (codes 010/011 are never taken)
module branch_cmp
  import pc_sequencer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_val == rs2_val);
  assign lt_s = ($signed(rs1_val) < $signed(rs2_val));
  assign lt_u = (rs1_val < rs2_val);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = !lt_s;
      F3_BLTU: taken = lt_u;
      F3_BGEU: taken = !lt_u;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Next-PC controller for the single-cycle core. Drives the PC register's
// select/target each cycle, resolves branches/JAL/JALR, sequences reset,
// stall, halt/resume and misaligned-target traps, and counts retirements.
//   clk, rst_n          clock, asynchronous active-low reset
//   pc_in               current PC register value
//   inst_valid, stall   instruction available / hazard hold
//   branch, jal, jalr   decoded control-transfer type (one-hot or none)
//   funct3, rs1_val, rs2_val  branch condition and operands
//   imm                 sign-extended B/J offset
//   jalr_base           rs1+imm from the ALU
//   halt_req, resume    enter / leave HALT
//   pc_sel, pc_target   PC update select and offset/absolute value
//   flush, trap         single-cycle redirect / misaligned pulses
//   halted              high while in HALT
//   instret             retired-instruction counter (wraps)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  input  logic        inst_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        jal,
  input  logic        jalr,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [31:0] jalr_base,
  input  logic        halt_req,
  input  logic        resume,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        trap,
  output logic        halted,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  pc_sel_e     sel_c;
  logic        retire;
  logic        br_taken;
  logic [31:0] jalr_tgt;

  branch_cmp u_branch_cmp (
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .taken   (br_taken)
  );

  // JALR clears bit 0 of the computed address.
  assign jalr_tgt = jalr_base & 32'hFFFF_FFFE;

  always_comb begin
    state_d   = state_q;
    sel_c     = PC_SEQ;
    pc_target = 32'h0;
    flush     = 1'b0;
    trap      = 1'b0;
    retire    = 1'b0;
    case (state_q)
      RESET: begin
        sel_c   = PC_ZERO;
        state_d = RUN;
      end
      RUN: begin
        if (!inst_valid || stall) begin
          // Stall has priority over everything, including halt_req.
          sel_c     = PC_ABS;
          pc_target = pc_in;
        end else begin
          retire = 1'b1;
          if (halt_req) begin
            sel_c     = PC_ABS;
            pc_target = pc_in;
            state_d   = HALT;
          end else if (jalr) begin
            flush = 1'b1;
            sel_c = PC_ABS;
            if (is_misaligned(jalr_tgt)) begin
              trap      = 1'b1;
              pc_target = TRAP_VEC;
            end else begin
              pc_target = jalr_tgt;
            end
          end else if (jal || (branch && br_taken)) begin
            // pc_in is word aligned, so (pc_in+imm)[1] reduces to imm[1].
            flush = 1'b1;
            if (is_misaligned(imm)) begin
              trap      = 1'b1;
              sel_c     = PC_ABS;
              pc_target = TRAP_VEC;
            end else begin
              sel_c     = PC_REL;
              pc_target = imm;
            end
          end
        end
      end
      HALT: begin
        if (resume) begin
          // Step past the instruction that requested the halt.
          sel_c   = PC_SEQ;
          state_d = RUN;
        end else begin
          sel_c     = PC_ABS;
          pc_target = pc_in;
        end
      end
      default: begin
        sel_c   = PC_ZERO;
        state_d = RESET;
      end
    endcase
  end

  assign instret_d = retire ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET;
      instret_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign pc_sel  = sel_c;
  assign halted  = (state_q == HALT);
  assign instret = instret_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the single-cycle core. Each cycle it decides how the program counter register updates by driving that register's 2-bit select and 32-bit target/offset inputs. It resolves branches, JAL and JALR, and sequences reset, stall, halt/resume and misaligned-target traps. It also keeps a retired-instruction counter.

## Interface
Parameters:
- TRAP_VEC, 32'h0000_0100, absolute address loaded on a misaligned control-transfer target.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_in  in  32  current PC register value.
- inst_valid  in  1  instruction at pc_in is available this cycle.
- stall  in  1  hazard stall; hold PC.
- branch / jal / jalr  in  1 each  decoded control-transfer type; at most one high per cycle.
- funct3  in  3  branch condition.
- rs1_val, rs2_val  in  32 each  branch operands.
- imm  in  32  sign-extended B/J offset.
- jalr_base  in  32  rs1+imm from the ALU.
- halt_req  in  1  ECALL/EBREAK decoded.
- resume  in  1  leave HALT.
- pc_sel  out  2  PC update select: 00 = +4, 01 = +target, 10 = load target, 11 = clear to 0.
- pc_target  out  32  offset or absolute value for the PC.
- flush  out  1  one-cycle pulse on any non-sequential redirect.
- trap  out  1  one-cycle pulse on a misaligned target.
- halted  out  1  high in HALT.
- instret  out  32  retired-instruction count.

## Operation
- FSM states: RESET, RUN, HALT.
- pc_sel, pc_target, flush and trap are combinational from the state and the current inputs. The PC register samples them on the same edge.
- RESET:
  - pc_sel = 11, pc_target = 0, flush = 0, trap = 0.
  - Next state: RUN.
- RUN, with either inst_valid = 0 or stall = 1:
  - Hold the PC: pc_sel = 10, pc_target = pc_in.
  - No retire, no flush.
- RUN, with inst_valid = 1 and stall = 0, first match wins:
  1. halt_req: hold (10, pc_in). Next state HALT. Retire.
  2. jalr: target = {jalr_base[31:1], 1'b0}.
     - If target[1] = 1: trap; select 10 with TRAP_VEC.
     - Otherwise select 10 with the target.
     - Both cases: flush.
  3. jal: the misaligned check is (pc_in+imm)[1], which equals imm[1].
     - If misaligned: trap; select 10 with TRAP_VEC.
     - Otherwise select 01 with imm.
     - Both cases: flush.
  4. branch taken: same misaligned rule and outputs as jal.
  5. Otherwise: pc_sel = 00, pc_target = 0.
  - Every case in this list retires one instruction (instret += 1), including trap cases.
- Branch condition (funct3):
  - 000 EQ, 001 NE: equality.
  - 100 LT, 101 GE: signed compare.
  - 110 LTU, 111 GEU: unsigned compare.
  - 010 and 011: not taken.
- HALT:
  - Hold (10, pc_in); halted = 1.
  - When resume = 1: pc_sel = 00 (step past the halting instruction), next state RUN.
  - halt_req is ignored in HALT.
- instret wraps from 32'hFFFF_FFFF to 0.

## Timing
- rst_n low asynchronously forces state = RESET and instret = 0.
- While rst_n is low, the outputs are pc_sel = 11, pc_target = 0, flush = 0, trap = 0, halted = 0.
- First posedge after rst_n rises: PC clears to 0 and state moves to RUN.
- The first instruction at address 0 can retire on the second posedge after release.
- Redirect latency is zero cycles: the new PC is valid after the same edge on which the branch is resolved.
- flush and trap are high only in the resolving cycle.
- rst_n asserted mid-operation (including in HALT) aborts immediately. instret is lost.
- Simultaneous events:
  - stall = 1 together with halt_req: the stall wins; halt_req is re-evaluated next cycle.
  - resume = 1 while not in HALT: ignored.

## Structure
- Package pc_sequencer_pkg holds:
  - pc_sel_e enum: PC_SEQ = 2'b00, PC_REL = 2'b01, PC_ABS = 2'b10, PC_ZERO = 2'b11.
  - state_e enum: RESET, RUN, HALT.
  - funct3 localparams: F3_BEQ … F3_BGEU.
- Sub-module branch_cmp is purely combinational: funct3, rs1_val, rs2_val -> taken.
- The FSM, priority mux and counter stay in pc_sequencer.

## Test plan
- Reset release with inst_valid = 1: pc_sel = 11 on the first edge, then 00; pc_in model steps 0 -> 4 -> 8; instret = 2 after 3 edges.
- BLT with rs1 = 32'hFFFF_FFFF, rs2 = 1, imm = -8, pc_in = 16: taken, pc_sel = 01, pc_target = 32'hFFFF_FFF8, flush pulse; the same operands as BLTU are not taken, pc_sel = 00.
- JALR with jalr_base = 32'h0000_0203: pc_sel = 10, pc_target = 32'h0000_0202, so target[1] = 1: trap, pc_target = 32'h0000_0100.
- JALR with jalr_base = 32'h0000_0201: no trap, pc_target = 32'h0000_0200.
- stall = 1 for 3 cycles with pc_in = 40: pc_sel = 10 and pc_target = 40 each cycle, instret unchanged.
- halt_req at pc_in = 12: halted = 1, PC held; resume 5 cycles later: pc_sel = 00, next pc_in = 16, halted = 0.
- rst_n pulsed low while in HALT: state = RESET and instret = 0 immediately, pc_sel = 11.
